// File: rtl/nios2_debug_slave_ocimem.sv
// Debug RAM stage: executes JTAG reads/writes from the debug slave wrapper with auto-incrementing address.
// Latency: load-only 1 cycle, write 2 cycles, read 3 cycles to monitor_ready; CPU read data 1 cycle after acceptance.
// Backpressure: debug strobes outside IDLE are dropped and flag monitor_error; CPU stalled via avs_waitrequest (NIOS2_OCIMEM_AVS_PORT_EN).
module nios2_debug_slave_ocimem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] op_addr_q;
    logic              op_legal_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mondreg_q;
    logic              ready_q;
    logic              error_q;

    logic [31:0]       mem [0:DEPTH-1];
    logic [31:0]       ram_dout_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic              dbg_we;

    logic              any_strobe;
    logic [ADDR_W-1:0] jdo_addr;
    logic              jdo_unused;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({{(32-ADDR_W){1'b0}}, a} < 32'(DEPTH));
    endfunction

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jdo_addr   = jdo[17+ADDR_W-1:17];
    assign jdo_unused = ^{jdo[37:35], jdo[2:0]};
    assign dbg_we     = (state_q == WR) & op_legal_q;

    assign MonDReg       = mondreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

    // Debug command FSM: decode strobes in IDLE, sequence RAM access, report completion/error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            op_addr_q  <= '0;
            op_legal_q <= 1'b0;
            wdata_q    <= '0;
            mondreg_q  <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_action_ocimem_b) begin
                        op_addr_q  <= addr_q;
                        op_legal_q <= in_range(addr_q);
                        wdata_q    <= jdo[34:3];
                        addr_q     <= addr_q + ADDR_W'(1);
                        ready_q    <= 1'b0;
                        error_q    <= 1'b0;
                        state_q    <= WR;
                    end else if (take_action_ocimem_a) begin
                        error_q <= 1'b0;
                        if (jdo[34]) begin
                            op_addr_q  <= jdo_addr;
                            op_legal_q <= in_range(jdo_addr);
                            addr_q     <= jdo_addr + ADDR_W'(1);
                            ready_q    <= 1'b0;
                            state_q    <= RD;
                        end else begin
                            // load-only: nothing touches the RAM, so it completes at once
                            addr_q  <= jdo_addr;
                            ready_q <= 1'b1;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        op_addr_q  <= addr_q;
                        op_legal_q <= in_range(addr_q);
                        addr_q     <= addr_q + ADDR_W'(1);
                        ready_q    <= 1'b0;
                        error_q    <= 1'b0;
                        state_q    <= RD;
                    end
                end
                RD: begin
                    if (any_strobe) error_q <= 1'b1;
                    state_q <= CAP;
                end
                CAP: begin
                    if (op_legal_q) mondreg_q <= ram_dout_q;
                    ready_q <= 1'b1;
                    error_q <= error_q | ~op_legal_q | any_strobe;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    error_q <= error_q | ~op_legal_q | any_strobe;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef NIOS2_OCIMEM_AVS_PORT_EN
    logic cpu_rd_acc;
    logic cpu_wr_acc;
    logic cpu_rd_q;

    // Debug owns the RAM outside IDLE or whenever a strobe is pending
    assign avs_waitrequest = (state_q != IDLE) | any_strobe;
    assign cpu_rd_acc      = avs_read & ~avs_waitrequest;
    assign cpu_wr_acc      = avs_write & ~avs_waitrequest;
    assign ram_addr        = (state_q == IDLE) ? avs_address : op_addr_q;
    assign ram_we          = dbg_we | (cpu_wr_acc & in_range(avs_address));
    assign ram_wdata       = (state_q == WR) ? wdata_q : avs_writedata;
    assign avs_readdata    = cpu_rd_q ? ram_dout_q : 32'h0;

    // Marks the cycle after an accepted in-range CPU read so RAM data is presented
    always_ff @(posedge clk) begin
        if (reset) cpu_rd_q <= 1'b0;
        else       cpu_rd_q <= cpu_rd_acc & in_range(avs_address);
    end
`else
    logic avs_unused;

    assign avs_unused      = ^{avs_address, avs_read, avs_write, avs_writedata};
    assign avs_waitrequest = 1'b0;
    assign avs_readdata    = 32'h0;
    assign ram_addr        = op_addr_q;
    assign ram_we          = dbg_we;
    assign ram_wdata       = wdata_q;
`endif

    // Single-port RAM with registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_dout_q <= mem[ram_addr];
    end

endmodule

// File: tb/tb_nios2_debug_slave_ocimem.sv
module tb_nios2_debug_slave_ocimem;

`ifdef NIOS2_OCIMEM_AVS_PORT_EN
    localparam bit AVS_EN = 1'b1;
`else
    localparam bit AVS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_b, take_na;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;

    logic [31:0] mon, avs_rdata, mon2, avs_rdata2;
    logic        rdy, err, avs_wait, rdy2, err2, avs_wait2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios2_debug_slave_ocimem #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
        .take_no_action_ocimem_a(take_na),
        .MonDReg(mon), .monitor_ready(rdy), .monitor_error(err),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_rdata),
        .avs_waitrequest(avs_wait)
    );

    nios2_debug_slave_ocimem #(.ADDR_W(8), .DEPTH(200)) dut200 (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
        .take_no_action_ocimem_a(take_na),
        .MonDReg(mon2), .monitor_ready(rdy2), .monitor_error(err2),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_rdata2),
        .avs_waitrequest(avs_wait2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Each strobe task returns one cycle after the strobe (cycle 1)
    task automatic load(input logic [7:0] a, input logic rd);
        jdo = '0; jdo[34] = rd; jdo[24:17] = a; take_a = 1'b1;
        tick();
        take_a = 1'b0; jdo = '0;
    endtask

    task automatic dwrite(input logic [31:0] d);
        jdo = '0; jdo[34:3] = d; take_b = 1'b1;
        tick();
        take_b = 1'b0; jdo = '0;
    endtask

    task automatic nread();
        take_na = 1'b1;
        tick();
        take_na = 1'b0;
    endtask

    initial begin
        reset = 1'b1; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_mon", mon, 32'h0);
        chk("rst_rdy", {31'b0, rdy}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_avs_rdata", avs_rdata, 32'h0);
        chk("rst_avs_wait", {31'b0, avs_wait}, 32'h0);

        // load-only 0x10: ready in cycle 1
        jdo = '0; jdo[24:17] = 8'h10; take_a = 1'b1;
        #1;
        chk("strobe_wait", {31'b0, avs_wait}, {31'b0, AVS_EN});
        tick();
        take_a = 1'b0; jdo = '0;
        chk("load_rdy", {31'b0, rdy}, 32'h1);
        chk("load_mon", mon, 32'h0);
        chk("load_err", {31'b0, err}, 32'h0);

        // write 0xDEADBEEF at 0x10
        dwrite(32'hDEADBEEF);
        chk("wr_c1_rdy", {31'b0, rdy}, 32'h0);
        tick();
        chk("wr_c2_rdy", {31'b0, rdy}, 32'h1);

        // read via load 0x10: MonDReg valid cycle 3
        load(8'h10, 1'b1);
        chk("rd_c1_rdy", {31'b0, rdy}, 32'h0);
        tick();
        chk("rd_c2_rdy", {31'b0, rdy}, 32'h0);
        chk("rd_c2_mon", mon, 32'h0);
        tick();
        chk("rd_c3_rdy", {31'b0, rdy}, 32'h1);
        chk("rd_c3_mon", mon, 32'hDEADBEEF);

        // addr is now 0x11: a write lands there
        dwrite(32'hCAFEF00D); tick();
        load(8'h11, 1'b1); tick(); tick();
        chk("addr_post_rd", mon, 32'hCAFEF00D);

        // wrap: prime 0x01, load 0xFF, two writes -> 0xFF, 0x00, addr 0x01
        load(8'h01, 1'b0);
        dwrite(32'hA5A5A5A5); tick();
        load(8'hFF, 1'b0);
        dwrite(32'h11111111); tick();
        chk("wr_ff_err", {31'b0, err}, 32'h0);
        chk("wr_ff_err_d200", {31'b0, err2}, 32'h1);
        chk("wr_ff_rdy_d200", {31'b0, rdy2}, 32'h1);
        dwrite(32'h22222222); tick();
        nread(); tick(); tick();
        chk("wrap_addr01", mon, 32'hA5A5A5A5);
        load(8'hFF, 1'b1); tick(); tick();
        chk("wrap_rd_ff", mon, 32'h11111111);
        nread(); tick(); tick();
        chk("wrap_rd_00", mon, 32'h22222222);
        chk("d200_mon_before", mon2, 32'h22222222);

        // DEPTH=200: read at 0xC8 is illegal
        load(8'hC8, 1'b1);
        chk("ill_c1_rdy", {31'b0, rdy2}, 32'h0);
        chk("ill_c1_err", {31'b0, err2}, 32'h0);
        tick(); tick();
        chk("ill_rdy", {31'b0, rdy2}, 32'h1);
        chk("ill_err", {31'b0, err2}, 32'h1);
        chk("ill_mon", mon2, 32'h22222222);
        chk("legal_err_256", {31'b0, err}, 32'h0);

        // strobe while busy is dropped and flags error
        load(8'h10, 1'b1);
        take_na = 1'b1; tick(); take_na = 1'b0;
        tick();
        chk("busy_rdy", {31'b0, rdy}, 32'h1);
        chk("busy_err", {31'b0, err}, 32'h1);
        chk("busy_mon", mon, 32'hDEADBEEF);

        // prime 0x05 via debug, then CPU write concurrent with a debug read
        load(8'h05, 1'b0);
        dwrite(32'h0BADF00D); tick();
        avs_address = 8'h05; avs_writedata = 32'h12345678; avs_write = 1'b1;
        take_na = 1'b1;
        #1;
        chk("cpu_c0_wait", {31'b0, avs_wait}, {31'b0, AVS_EN});
        tick();
        take_na = 1'b0;
        chk("cpu_c1_wait", {31'b0, avs_wait}, {31'b0, AVS_EN});
        tick();
        chk("cpu_c2_wait", {31'b0, avs_wait}, {31'b0, AVS_EN});
        tick();
        chk("cpu_c3_wait", {31'b0, avs_wait}, 32'h0);
        tick();
        avs_write = 1'b0;
        avs_read = 1'b1;
        #1;
        chk("cpu_rd_wait", {31'b0, avs_wait}, 32'h0);
        tick();
        avs_read = 1'b0;
        chk("cpu_rdata", avs_rdata, AVS_EN ? 32'h12345678 : 32'h0);
        load(8'h05, 1'b1); tick(); tick();
        chk("dbg_rd_05", mon, AVS_EN ? 32'h12345678 : 32'h0BADF00D);

        // CPU read beyond DEPTH returns 0
        avs_address = 8'hC8; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        chk("cpu_oor_rdata", avs_rdata2, 32'h0);

        // reset while in RD, then a fresh read at 0x00
        nread();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_mon", mon, 32'h0);
        chk("rst2_rdy", {31'b0, rdy}, 32'h0);
        chk("rst2_err", {31'b0, err}, 32'h0);
        chk("rst2_avs_rdata", avs_rdata, 32'h0);
        nread(); tick(); tick();
        chk("post_rst_rdy", {31'b0, rdy}, 32'h1);
        chk("post_rst_err", {31'b0, err}, 32'h0);
        chk("post_rst_mon", mon, 32'h22222222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
